// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ACCESS -> READ, fixed 3-cycle latency.
// Optional round-robin arbitration selected by defining MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_mar,
  output logic [DW-1:0] mem_mdr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ
  } state_t;

  state_t state, state_nx;

  logic          m0, m1;
  logic          gnt, gnt_port;
  logic          ack0_nx, ack1_nx;
  logic [DW-1:0] rdata0_nx, rdata1_nx;
  logic [AW-1:0] mar_nx;
  logic [DW-1:0] mdr_nx;
  logic          we_nx, busy_nx, owner_nx;

  // a port whose ack is high this cycle cannot win
  assign m0 = req0 & ~ack0;
  assign m1 = req1 & ~ack1;

  // pick the winner among unmasked requests
  always_comb begin
    gnt      = 1'b0;
    gnt_port = owner;
`ifdef MEM_ARB_RR_EN
    if (m0 && m1) begin
      gnt      = 1'b1;
      gnt_port = ~owner;
    end else if (m0) begin
      gnt      = 1'b1;
      gnt_port = 1'b0;
    end else if (m1) begin
      gnt      = 1'b1;
      gnt_port = 1'b1;
    end
`else
    if (m0) begin
      gnt      = 1'b1;
      gnt_port = 1'b0;
    end else if (m1 && !req0) begin
      gnt      = 1'b1;
      gnt_port = 1'b1;
    end
`endif
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      mem_mar <= '0;
      mem_mdr <= '0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      owner   <= 1'b1;
    end else begin
      state   <= state_nx;
      ack0    <= ack0_nx;
      ack1    <= ack1_nx;
      rdata0  <= rdata0_nx;
      rdata1  <= rdata1_nx;
      mem_mar <= mar_nx;
      mem_mdr <= mdr_nx;
      mem_we  <= we_nx;
      busy    <= busy_nx;
      owner   <= owner_nx;
    end
  end

  // next-state sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt) state_nx = ACCESS;
      ACCESS:  state_nx = READ;
      READ:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    ack0_nx   = 1'b0;
    ack1_nx   = 1'b0;
    rdata0_nx = rdata0;
    rdata1_nx = rdata1;
    mar_nx    = mem_mar;
    mdr_nx    = mem_mdr;
    we_nx     = mem_we;
    owner_nx  = owner;
    unique case (state)
      IDLE: begin
        if (gnt) begin
          mar_nx   = gnt_port ? addr1 : addr0;
          mdr_nx   = gnt_port ? wdata1 : wdata0;
          we_nx    = gnt_port ? we1 : we0;
          owner_nx = gnt_port;
        end
      end
      ACCESS: we_nx = 1'b0;
      READ: begin
        if (owner) begin
          rdata1_nx = mem_out;
          ack1_nx   = 1'b1;
        end else begin
          rdata0_nx = mem_out;
          ack0_nx   = 1'b1;
        end
      end
      default: we_nx = 1'b0;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences,
// and randomized traffic against a cycle-scheduled transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_mar, mem_mdr;
  logic        mem_we;
  logic [15:0] mem_out = '0;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_mar(mem_mar), .mem_mdr(mem_mdr),
    .mem_we(mem_we), .mem_out(mem_out),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];

  initial for (int i = 0; i < 65536; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_mar] <= mem_mdr;
    mem_out <= mem_we ? mem_mdr : mem[mem_mar];
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input bit r, input bit w,
                          input logic [15:0] a,
                          input logic [15:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_mar"}, 32'(mem_mar), 32'h0);
    chk({nm, "_mdr"}, 32'(mem_mdr), 32'h0);
    chk({nm, "_we"}, 32'(mem_we), 32'h0);
    chk({nm, "_ack"}, 32'({ack1, ack0}), 32'h0);
    chk({nm, "_rd0"}, 32'(rdata0), 32'h0);
    chk({nm, "_rd1"}, 32'(rdata1), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_owner"}, 32'(owner), 32'h1);
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic single(input bit p, input bit w,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        input logic [15:0] exp_rd,
                        input string nm);
    logic [15:0] oth;
    int first, nack, noth, nwe;
    oth = p ? rdata0 : rdata1;
    first = 0; nack = 0; noth = 0; nwe = 0;
    set_port(!p, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(p, 1'b1, w, a, d);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_we) nwe++;
      if (k == 1) begin
        chk({nm, "_owner"}, 32'(owner), 32'(p));
        chk({nm, "_mar"}, 32'(mem_mar), 32'(a));
      end
      if (p ? ack1 : ack0) begin
        nack++;
        if (first == 0) begin
          first = k;
          chk({nm, "_rdata"}, 32'(p ? rdata1 : rdata0), 32'(exp_rd));
          set_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
      if (p ? ack0 : ack1) noth++;
    end
    chk({nm, "_lat"}, 32'(first), 32'd3);
    chk({nm, "_nack"}, 32'(nack), 32'd1);
    chk({nm, "_oth_ack"}, 32'(noth), 32'd0);
    chk({nm, "_we_pulses"}, 32'(nwe), 32'(w));
    chk({nm, "_oth_rd"}, 32'(p ? rdata0 : rdata1), 32'(oth));
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  int          seq [8];
  int          n, nack;
  bit          exp_p;
  bit          r_act [2];
  bit          r_we [2];
  logic [15:0] r_addr [2];
  logic [15:0] r_data [2];
  logic [15:0] shadow [16];
  int          g_cyc;
  bit          g_port, g_we, o_exp;
  logic [15:0] g_rd, mar_exp, mdr_exp;
  logic [15:0] rd_exp [2];
  bit          ae0, ae1, m0, m1, gnt, gp;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h3000, 16'h1234, 16'h1234};
    tbl[1] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    tbl[2] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b0, 16'h0010, 16'h5555, 16'hBEEF};
    tbl[5] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0001};
    tbl[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};

    do_reset();
    chk_reset_vals("reset");

    for (int i = 0; i < 9; i++)
      single(tbl[i].port, tbl[i].we, tbl[i].addr,
             tbl[i].data, tbl[i].exp_rd, $sformatf("vec%0d", i));

    // early drop of req and address change after grant
    set_port(0, 1'b1, 1'b0, 16'h3000, 16'h0);
    tick();
    chk("drop_busy", 32'(busy), 32'h1);
    req0 = 1'b0;
    tick();
    addr0 = 16'hFFFF;
    chk("drop_mar", 32'(mem_mar), 32'h3000);
    nack = 0;
    for (int k = 3; k <= 10; k++) begin
      tick();
      if (ack0) nack++;
      if (k == 3) begin
        chk("drop_ack", 32'(ack0), 32'h1);
        chk("drop_rd", 32'(rdata0), 32'h1234);
      end
    end
    chk("drop_nack", 32'(nack), 32'd1);
    chk("drop_mar_end", 32'(mem_mar), 32'h3000);

    // reset during READ of a port 1 read
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    chk("rstrd_busy1", 32'(busy), 32'h1);
    tick();
    chk("rstrd_busy2", 32'(busy), 32'h1);
    reset = 1'b0;
    req1 = 1'b0;
    tick();
    chk_reset_vals("rstrd");
    reset = 1'b1;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ack1) nack++;
    end
    chk("rstrd_no_ack1", 32'(nack), 32'd0);
    single(0, 1'b0, 16'h3000, 16'h0, 16'h1234, "rstrd_next");

    // reset during ACCESS of a write
    set_port(0, 1'b1, 1'b1, 16'h0042, 16'h00AA);
    tick();
    chk("rstwr_we", 32'(mem_we), 32'h1);
    reset = 1'b0;
    req0 = 1'b0;
    tick();
    chk("rstwr_we_after", 32'(mem_we), 32'h0);
    chk("rstwr_ack", 32'(ack0), 32'h0);
    reset = 1'b1;
    single(0, 1'b0, 16'h0042, 16'h0, 16'h00AA, "rstwr_read");

    // both ports hold req for 8 transactions
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h3000, 16'h0);
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      tick();
      if (ack0 && ack1) chk("both_dual_ack", 32'h1, 32'h0);
      if (ack0) begin seq[n] = 0; n++; end
      else if (ack1) begin seq[n] = 1; n++; end
      if (n == 8) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    chk("both_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_p = 1'(i % 2);
`else
      exp_p = 1'b0;
`endif
      chk($sformatf("both_grant%0d", i), 32'(seq[i]), 32'(exp_p));
    end
    for (int k = 0; k < 6; k++) tick();

    // randomized traffic against the transaction model
    do_reset();
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    for (int i = 0; i < 2; i++) begin
      r_act[i] = 1'b0;
      rd_exp[i] = '0;
    end
    g_cyc = -100;
    g_port = 1'b0;
    g_we = 1'b0;
    g_rd = '0;
    o_exp = 1'b1;
    mar_exp = '0;
    mdr_exp = '0;
    for (int t = 0; t < 1500; t++) begin
      ae0 = (t == g_cyc + 3) && !g_port;
      ae1 = (t == g_cyc + 3) && g_port;
      if (ae0) rd_exp[0] = g_rd;
      if (ae1) rd_exp[1] = g_rd;
      chk("rnd_ack0", 32'(ack0), 32'(ae0));
      chk("rnd_ack1", 32'(ack1), 32'(ae1));
      chk("rnd_busy", 32'(busy),
          32'(t == g_cyc + 1 || t == g_cyc + 2));
      chk("rnd_we", 32'(mem_we), 32'(t == g_cyc + 1 && g_we));
      chk("rnd_mar", 32'(mem_mar), 32'(mar_exp));
      chk("rnd_mdr", 32'(mem_mdr), 32'(mdr_exp));
      chk("rnd_owner", 32'(owner), 32'(o_exp));
      chk("rnd_rd0", 32'(rdata0), 32'(rd_exp[0]));
      chk("rnd_rd1", 32'(rdata1), 32'(rd_exp[1]));
      if (ack0) r_act[0] = 1'b0;
      if (ack1) r_act[1] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!r_act[p] && $urandom_range(2) == 0) begin
          r_act[p] = 1'b1;
          r_we[p] = 1'($urandom_range(1));
          r_addr[p] = 16'h0200 | 16'($urandom_range(15));
          r_data[p] = 16'($urandom);
        end
        set_port(1'(p), r_act[p], r_we[p], r_addr[p], r_data[p]);
      end
      gnt = 1'b0;
      gp = 1'b0;
      if (t >= g_cyc + 3) begin
        m0 = req0 && !ae0;
        m1 = req1 && !ae1;
`ifdef MEM_ARB_RR_EN
        if (m0 && m1) begin gnt = 1'b1; gp = !o_exp; end
        else if (m0) begin gnt = 1'b1; gp = 1'b0; end
        else if (m1) begin gnt = 1'b1; gp = 1'b1; end
`else
        if (m0) begin gnt = 1'b1; gp = 1'b0; end
        else if (m1 && !req0) begin gnt = 1'b1; gp = 1'b1; end
`endif
      end
      if (gnt) begin
        g_cyc = t;
        g_port = gp;
        g_we = r_we[gp];
        o_exp = gp;
        mar_exp = r_addr[gp];
        mdr_exp = r_data[gp];
        if (g_we) shadow[r_addr[gp][3:0]] = r_data[gp];
        g_rd = shadow[r_addr[gp][3:0]];
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
